demux_1_4_tdm: RTL

//   Sequential 1:4 demultiplexer: inverse of the 4:1 channel mux.
//   - Accepts one data word per valid cycle and routes it to one of four registered output channels.
//   - Channel is chosen by an explicit select (S) or by an internal round-robin slot counter synchronised to a frame marker.
//   - Sits on the receive side of a 4-channel TDM link, fanning a serialised stream back out to per-channel consumers.

---
 rtl/demux_1_4_tdm.sv | 81 ++++++++
 1 files changed

// File: rtl/demux_1_4_tdm.sv
// Sequential 1:4 demultiplexer for the receive side of a 4-channel TDM link.
// Words are routed by an explicit select or by a frame-synchronised slot counter.
module demux_1_4_tdm #(
    parameter int W        = 1,
    parameter bit SYNC_CHK = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   I,
    input  logic           I_valid,
    input  logic [1:0]     S,
    input  logic           auto,
    input  logic           sync,
    output logic [4*W-1:0] Y,
    output logic [3:0]     Y_valid,
    output logic [1:0]     slot,
    output logic           frame_done,
    output logic           sync_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_nxt;
    logic [1:0] slot_nxt;
    logic [1:0] ch;
    logic       wr;
    logic       frame_done_nxt;
    logic       sync_err_nxt;

    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt      = state;
        slot_nxt       = slot;
        ch             = slot;
        wr             = 1'b0;
        frame_done_nxt = 1'b0;
        sync_err_nxt   = 1'b0;

        if (!auto) begin
            state_nxt = IDLE;
            slot_nxt  = 2'd0;
            ch        = S;
            wr        = I_valid;
        end else if (sync) begin
            // A sync always starts a new frame; a non-zero slot means the last frame was cut short.
            sync_err_nxt = SYNC_CHK && (state == RUN) && (slot != 2'd0);
            state_nxt    = RUN;
            ch           = 2'd0;
            wr           = I_valid;
            slot_nxt     = I_valid ? 2'd1 : 2'd0;
        end else if (state == RUN && I_valid) begin
            wr             = 1'b1;
            ch             = slot;
            slot_nxt       = slot + 2'd1;
            frame_done_nxt = (slot == 2'd3);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot       <= 2'd0;
            Y          <= '0;
            Y_valid    <= 4'b0000;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            slot       <= slot_nxt;
            Y_valid    <= wr ? (4'b0001 << ch) : 4'b0000;
            frame_done <= frame_done_nxt;
            sync_err   <= sync_err_nxt;
            for (int k = 0; k < 4; k++) begin
                if (wr && ch == 2'(k))
                    Y[W*k +: W] <= I;
            end
        end
    end

endmodule
